mem_bus_master: RTL and testbench
=================================

Name: mem_bus_master

Overview:
- Downstream of the MMU; the memory side of the core's single shared memory port.
- Accepts the MMU's one-cycle request pulse (physical address, mode, write data, strobes) and runs one AXI4-Lite read or write transaction.
- Returns one-cycle `response_enable` with `resp_data`.
- Exactly one transaction in flight; no queueing.

Parameters:
- ADDR_W, 32, AXI address width; `req_addr` is passed through unchanged.
- DATA_W, 32, data width; `wstrb` width is DATA_W/8.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- request_enable  in  1  one-cycle request pulse from the MMU
- req_mode  in  1  0 = MEMREQ_READ, 1 = MEMREQ_WRITE
- req_addr  in  ADDR_W  physical address
- req_wdata  in  DATA_W  write data
- req_wstrb  in  DATA_W/8  byte strobes
- response_enable  out  1  one-cycle completion pulse
- resp_data  out  DATA_W  read data; 0 for writes
- busy  out  1  high whenever state != IDLE
- m_axi_araddr out ADDR_W; m_axi_arvalid out 1; m_axi_arready in 1; m_axi_arprot out 3
- m_axi_rdata in DATA_W; m_axi_rresp in 2; m_axi_rvalid in 1; m_axi_rready out 1
- m_axi_awaddr out ADDR_W; m_axi_awvalid out 1; m_axi_awready in 1; m_axi_awprot out 3
- m_axi_wdata out DATA_W; m_axi_wstrb out DATA_W/8; m_axi_wvalid out 1; m_axi_wready in 1
- m_axi_bresp in 2; m_axi_bvalid in 1; m_axi_bready out 1
- access_fault  out  1  present only with MEM_BUS_ERR_EN

Behaviour:
- Reset (async, rst=1):
  - state = IDLE.
  - All valid/ready outputs, `response_enable`, `busy` and `access_fault` = 0.
  - All address, data and strobe registers = 0.
  - Reset mid-transaction abandons it; no response pulse is produced.
- Outputs: all registered. `arprot` and `awprot` are tied to 3'b000.
- IDLE:
  - On `request_enable`, latch addr/mode/wdata/wstrb.
  - Mode 0: `arvalid` = 1 next cycle, go to RD_ADDR.
  - Mode 1: `awvalid` = 1 and `wvalid` = 1 next cycle, go to WR_REQ.
- RD_ADDR:
  - Hold `arvalid` and `araddr` stable until `arvalid && arready`.
  - On handshake: `arvalid` = 0, `rready` = 1, go to RD_DATA.
- RD_DATA:
  - On `rvalid && rready`: capture `rdata` into `resp_data`, `rready` = 0, go to RESP.
- WR_REQ:
  - AW and W complete independently. Track each with a done flag.
  - Drop `awvalid` on the cycle after its handshake; same for `wvalid`.
  - Both handshakes in the same cycle is legal.
  - When both done (including the same cycle): `bready` = 1, go to WR_RESP.
- WR_RESP:
  - On `bvalid && bready`: `bready` = 0, `resp_data` = 0, go to RESP.
- RESP:
  - `response_enable` = 1 for exactly one cycle, then back to IDLE.
  - `resp_data` holds its value until the next completion.
- Latency:
  - With a zero-wait slave, the pulse appears 4 cycles after the request cycle for reads and 4 for writes.
  - Every stall cycle adds one cycle.
- `request_enable` in any state other than IDLE is ignored; the request is neither latched nor queued.
- Valid signals are never withdrawn before their handshake completes (AXI rule).
- Back-to-back requests: a request may arrive in the IDLE cycle immediately after RESP and is accepted.

Optional Feature:
- Macro: MEM_BUS_ERR_EN.
- Defined:
  - `access_fault` is asserted together with `response_enable` when the captured `rresp` or `bresp` is SLVERR (2'b10) or DECERR (2'b11).
  - `access_fault` is cleared on the next request accept.
  - Read data on error is forced to 0.
- Undefined:
  - The `access_fault` port is absent.
  - `rresp` and `bresp` are ignored.
  - `rdata` is returned as-is.

Test Plan:
- Read, zero-wait slave:
  - Stimulus: req_mode=0, req_addr=0x8000_0100; slave returns 0xDEADBEEF.
  - Required: `arvalid` high 1 cycle with `araddr` = 0x8000_0100; `response_enable` pulses once with `resp_data` = 0xDEADBEEF, 4 cycles after the request.
- Write with stalls:
  - Stimulus: addr 0x1000, wdata 0x12345678, wstrb 4'b0011; slave holds `awready` low 3 cycles and `wready` low 1 cycle.
  - Required: `wvalid` drops first; `awvalid` stays stable; `bready` rises only after both handshakes; one `response_enable` pulse with `resp_data` = 0.
- Request while busy:
  - Stimulus: second `request_enable` during RD_DATA.
  - Required: ignored; exactly one AR handshake and one response pulse.
- Async reset mid-transaction:
  - Stimulus: assert `rst` during WR_RESP, off-edge.
  - Required: outputs go to 0 immediately; no `response_enable`; the next read completes normally.
- Back-to-back:
  - Stimulus: read 0x2000, then a write request in the first IDLE cycle after RESP.
  - Required: both complete, pulses in order, no lost request.
- MEM_BUS_ERR_EN defined:
  - Stimulus: read with `rresp` = 2'b11.
  - Required: `access_fault` = 1 and `resp_data` = 0 during the pulse; cleared on the next accepted request.

Source files
------------

// File: rtl/mem_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_master
// Purpose  : Memory side of the core's single shared memory port. Takes a
//            one-cycle request pulse from the MMU and runs exactly one
//            AXI4-Lite read or write transaction. When it completes, the
//            block returns a one-cycle response pulse with the read data.
//            There is no queueing: requests that arrive while busy are
//            dropped.
// Ports    : clk, rst (async, active-high)
//            request_enable/req_mode/req_addr/req_wdata/req_wstrb : MMU request
//            response_enable/resp_data/busy                      : MMU response
//            m_axi_ar*/r*/aw*/w*/b*                              : AXI4-Lite master
//            access_fault                                        : only with MEM_BUS_ERR_EN
// Options  : `define MEM_BUS_ERR_EN enables the access_fault port. SLVERR and
//            DECERR responses then raise a fault, and read data is forced to 0
//            when an error is returned.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // MMU request / response
  input  logic                request_enable,
  input  logic                req_mode,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                response_enable,
  output logic [DATA_W-1:0]   resp_data,
  output logic                busy,
  // AXI4-Lite read address
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  output logic [2:0]          m_axi_arprot,
  // AXI4-Lite read data
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  // AXI4-Lite write address
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [2:0]          m_axi_awprot,
  // AXI4-Lite write data
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  // AXI4-Lite write response
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready
`ifdef MEM_BUS_ERR_EN
  ,
  output logic                access_fault
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    RESP    = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic                resp_en_q, resp_en_d;
  logic                busy_q, busy_d;

  logic aw_hs;
  logic w_hs;
  assign aw_hs = awvalid_q && m_axi_awready;
  assign w_hs  = wvalid_q && m_axi_wready;

`ifdef MEM_BUS_ERR_EN
  // Error seen on the completing R/B beat, held until it is published in RESP.
  logic err_q, err_d;
  logic fault_q, fault_d;
  logic rresp_err;
  logic bresp_err;
  assign rresp_err = (m_axi_rresp == 2'b10) || (m_axi_rresp == 2'b11);
  assign bresp_err = (m_axi_bresp == 2'b10) || (m_axi_bresp == 2'b11);
`else
  // Response codes carry no meaning without error reporting.
  logic unused_resp;
  assign unused_resp = ^{m_axi_rresp, m_axi_bresp};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      resp_data_q <= '0;
      resp_en_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MEM_BUS_ERR_EN
      err_q       <= 1'b0;
      fault_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      resp_data_q <= resp_data_d;
      resp_en_q   <= resp_en_d;
      busy_q      <= busy_d;
`ifdef MEM_BUS_ERR_EN
      err_q       <= err_d;
      fault_q     <= fault_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    resp_data_d = resp_data_q;
    resp_en_d   = 1'b0;
`ifdef MEM_BUS_ERR_EN
    err_d       = err_q;
    fault_d     = fault_q;
`endif

    case (state_q)
      IDLE: begin
        if (request_enable) begin
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          wstrb_d   = req_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
`ifdef MEM_BUS_ERR_EN
          err_d     = 1'b0;
          fault_d   = 1'b0;
`endif
          if (req_mode) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end

      RD_ADDR: begin
        if (arvalid_q && m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (m_axi_rvalid && rready_q) begin
          rready_d    = 1'b0;
          resp_data_d = m_axi_rdata;
`ifdef MEM_BUS_ERR_EN
          err_d = rresp_err;
          if (rresp_err) begin
            resp_data_d = '0;
          end
`endif
          state_d = RESP;
        end
      end

      WR_REQ: begin
        // AW and W retire independently; each valid drops right after its
        // own handshake while the other channel may still be stalled.
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_hs) begin
          awvalid_d = 1'b0;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
        end
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end

      WR_RESP: begin
        if (m_axi_bvalid && bready_q) begin
          bready_d    = 1'b0;
          resp_data_d = '0;
`ifdef MEM_BUS_ERR_EN
          err_d = bresp_err;
`endif
          state_d = RESP;
        end
      end

      RESP: begin
        // The pulse register is loaded here so it is visible in the
        // following cycle, when the FSM is already back in IDLE and able to
        // accept a back-to-back request.
        resp_en_d = 1'b1;
`ifdef MEM_BUS_ERR_EN
        fault_d   = err_q;
`endif
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered busy flag that tracks the state register exactly.
  assign busy_d = (state_d != IDLE);

  assign response_enable = resp_en_q;
  assign resp_data       = resp_data_q;
  assign busy            = busy_q;
  assign m_axi_araddr    = addr_q;
  assign m_axi_arvalid   = arvalid_q;
  assign m_axi_arprot    = 3'b000;
  assign m_axi_rready    = rready_q;
  assign m_axi_awaddr    = addr_q;
  assign m_axi_awvalid   = awvalid_q;
  assign m_axi_awprot    = 3'b000;
  assign m_axi_wdata     = wdata_q;
  assign m_axi_wstrb     = wstrb_q;
  assign m_axi_wvalid    = wvalid_q;
  assign m_axi_bready    = bready_q;
`ifdef MEM_BUS_ERR_EN
  assign access_fault    = fault_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_master
// Purpose  : Directed self-checking bench for mem_bus_master. A configurable
//            AXI4-Lite slave supplies per-channel stall counts. A negedge
//            monitor records handshakes, response pulses and protocol
//            violations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        request_enable = 1'b0;
  logic        req_mode = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        response_enable;
  logic [31:0] resp_data;
  logic        busy;
  logic [31:0] m_axi_araddr;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b0;
  logic [2:0]  m_axi_arprot;
  logic [31:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = '0;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready;
  logic [31:0] m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [2:0]  m_axi_awprot;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [1:0]  m_axi_bresp = '0;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;
`ifdef MEM_BUS_ERR_EN
  logic        access_fault;
`endif

  mem_bus_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .request_enable(request_enable), .req_mode(req_mode), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .response_enable(response_enable), .resp_data(resp_data), .busy(busy),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_arprot(m_axi_arprot),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_awprot(m_axi_awprot),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready)
`ifdef MEM_BUS_ERR_EN
    , .access_fault(access_fault)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // ---------------- slave configuration and model ----------------
  int          ar_stall = 0, r_stall = 0, aw_stall = 0, w_stall = 0, b_stall = 0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  s_rresp = '0;
  logic [1:0]  s_bresp = '0;

  initial begin
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (m_axi_arvalid) begin m_axi_arready = (ar_cnt >= ar_stall); ar_cnt++; end
      else begin m_axi_arready = 1'b0; ar_cnt = 0; end
      if (m_axi_awvalid) begin m_axi_awready = (aw_cnt >= aw_stall); aw_cnt++; end
      else begin m_axi_awready = 1'b0; aw_cnt = 0; end
      if (m_axi_wvalid) begin m_axi_wready = (w_cnt >= w_stall); w_cnt++; end
      else begin m_axi_wready = 1'b0; w_cnt = 0; end
      if (m_axi_rready) begin
        m_axi_rvalid = (r_cnt >= r_stall);
        m_axi_rdata  = m_axi_rvalid ? s_rdata : 32'h0;
        m_axi_rresp  = s_rresp;
        r_cnt++;
      end else begin m_axi_rvalid = 1'b0; r_cnt = 0; end
      if (m_axi_bready) begin
        m_axi_bvalid = (b_cnt >= b_stall);
        m_axi_bresp  = s_bresp;
        b_cnt++;
      end else begin m_axi_bvalid = 1'b0; b_cnt = 0; end
    end
  end

  // ---------------- negedge monitor ----------------
  int          ar_hs = 0, aw_hs = 0, w_hs = 0, arv_cycles = 0, viol = 0;
  int          aw_hs_cyc = 0, w_hs_cyc = 0, bready_rise_cyc = 0;
  int          pulse_cnt = 0, pulse_cyc = 0;
  logic [31:0] ar_addr_seen = '0, aw_addr_seen = '0, wdata_seen = '0;
  logic [3:0]  wstrb_seen = '0;
  logic [31:0] pulse_data = '0;
  logic [31:0] pulse_log [16];
  logic        pulse_fault = 1'b0;
  logic        p_arv = 0, p_arr = 0, p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_bready = 0;
  logic [31:0] p_araddr = '0, p_awaddr = '0, p_wdata = '0;

  always @(negedge clk) begin
    if (rst) begin
      p_arv = 0; p_awv = 0; p_wv = 0; p_bready = 0;
    end else begin
      if (p_arv && !p_arr && (!m_axi_arvalid || m_axi_araddr !== p_araddr)) viol++;
      if (p_awv && !p_awr && (!m_axi_awvalid || m_axi_awaddr !== p_awaddr)) viol++;
      if (p_wv && !p_wr && (!m_axi_wvalid || m_axi_wdata !== p_wdata)) viol++;
      if (m_axi_arvalid) arv_cycles++;
      if (m_axi_arvalid && m_axi_arready) begin ar_hs++; ar_addr_seen = m_axi_araddr; end
      if (m_axi_awvalid && m_axi_awready) begin aw_hs++; aw_hs_cyc = cyc; aw_addr_seen = m_axi_awaddr; end
      if (m_axi_wvalid && m_axi_wready) begin
        w_hs++; w_hs_cyc = cyc; wdata_seen = m_axi_wdata; wstrb_seen = m_axi_wstrb;
      end
      if (m_axi_bready && !p_bready) bready_rise_cyc = cyc;
      if (response_enable) begin
        pulse_cnt++;
        pulse_cyc  = cyc;
        pulse_data = resp_data;
        pulse_log[pulse_cnt & 15] = resp_data;
`ifdef MEM_BUS_ERR_EN
        pulse_fault = access_fault;
`endif
      end
      p_arv = m_axi_arvalid; p_arr = m_axi_arready; p_araddr = m_axi_araddr;
      p_awv = m_axi_awvalid; p_awr = m_axi_awready; p_awaddr = m_axi_awaddr;
      p_wv  = m_axi_wvalid;  p_wr  = m_axi_wready;  p_wdata  = m_axi_wdata;
      p_bready = m_axi_bready;
    end
  end

  // ---------------- stimulus helpers (no comparisons inside) ----------------
  // Called at posedge+1; returns at posedge+1 one cycle later.
  task automatic issue(input logic mode, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] ws, output int rc);
    request_enable = 1'b1; req_mode = mode; req_addr = addr;
    req_wdata = wd; req_wstrb = ws; rc = cyc;
    @(posedge clk); #1;
    request_enable = 1'b0;
  endtask

  task automatic wait_pulses(input int target, output bit ok);
    for (int i = 0; i < 60 && pulse_cnt < target; i++) @(posedge clk);
    #1;
    ok = (pulse_cnt >= target);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic [31:0] outs;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    outs = {m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid,
            m_axi_bready, response_enable, busy, 25'd0};
    checks++; if (outs !== 32'h0) begin failures++; $display("FAIL reset_ctrl: got %h expected 0", outs); end
    checks++; if ({m_axi_araddr, m_axi_awaddr, m_axi_wdata, resp_data} !== 128'h0) begin
      failures++; $display("FAIL reset_data: got %h/%h/%h/%h expected 0", m_axi_araddr, m_axi_awaddr, m_axi_wdata, resp_data); end
    checks++; if ({m_axi_wstrb, m_axi_arprot, m_axi_awprot} !== 10'h0) begin
      failures++; $display("FAIL reset_strb_prot: got %h expected 0", {m_axi_wstrb, m_axi_arprot, m_axi_awprot}); end
  endtask

  task automatic test_read_zero_wait;
    int rc, p0, a0, h0; bit ok;
    p0 = pulse_cnt; a0 = arv_cycles; h0 = ar_hs;
    s_rdata = 32'hDEADBEEF;
    issue(1'b0, 32'h8000_0100, 32'h0, 4'h0, rc);
    checks++; if (m_axi_arvalid !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL rd_arvalid_busy: got %b%b expected 11", m_axi_arvalid, busy); end
    wait_pulses(p0 + 1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rd_timeout: got no pulse expected pulse"); end
    checks++; if (pulse_cyc - rc != 4) begin failures++; $display("FAIL rd_latency: got %0d expected 4", pulse_cyc - rc); end
    checks++; if (pulse_data !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data: got %h expected deadbeef", pulse_data); end
    checks++; if (arv_cycles - a0 != 1) begin failures++; $display("FAIL rd_arvalid_cycles: got %0d expected 1", arv_cycles - a0); end
    checks++; if (ar_hs - h0 != 1 || ar_addr_seen !== 32'h8000_0100) begin
      failures++; $display("FAIL rd_ar_hs: got %0d@%h expected 1@80000100", ar_hs - h0, ar_addr_seen); end
    idle_cycles(4);
    checks++; if (pulse_cnt - p0 != 1) begin failures++; $display("FAIL rd_pulse_count: got %0d expected 1", pulse_cnt - p0); end
    checks++; if (resp_data !== 32'hDEADBEEF || busy !== 1'b0) begin
      failures++; $display("FAIL rd_hold: got %h busy=%b expected deadbeef busy=0", resp_data, busy); end
  endtask

  task automatic test_write_stalls;
    int rc, p0, v0; bit ok;
    p0 = pulse_cnt; v0 = viol;
    aw_stall = 3; w_stall = 1;
    issue(1'b1, 32'h0000_1000, 32'h12345678, 4'b0011, rc);
    wait_pulses(p0 + 1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL wr_timeout: got no pulse expected pulse"); end
    checks++; if (pulse_cyc - rc != 7) begin failures++; $display("FAIL wr_latency: got %0d expected 7", pulse_cyc - rc); end
    checks++; if (!(w_hs_cyc < aw_hs_cyc)) begin failures++; $display("FAIL wr_w_first: got w@%0d aw@%0d expected w before aw", w_hs_cyc, aw_hs_cyc); end
    checks++; if (bready_rise_cyc != aw_hs_cyc + 1) begin
      failures++; $display("FAIL wr_bready_rise: got %0d expected %0d", bready_rise_cyc, aw_hs_cyc + 1); end
    checks++; if (pulse_data !== 32'h0) begin failures++; $display("FAIL wr_resp_data: got %h expected 0", pulse_data); end
    checks++; if ({aw_addr_seen, wdata_seen, wstrb_seen} !== {32'h1000, 32'h12345678, 4'b0011}) begin
      failures++; $display("FAIL wr_payload: got %h %h %b expected 1000 12345678 0011", aw_addr_seen, wdata_seen, wstrb_seen); end
    checks++; if (viol != v0) begin failures++; $display("FAIL wr_valid_stable: got %0d violations expected 0", viol - v0); end
    idle_cycles(3);
    checks++; if (pulse_cnt - p0 != 1) begin failures++; $display("FAIL wr_pulse_count: got %0d expected 1", pulse_cnt - p0); end
    aw_stall = 0; w_stall = 0;
  endtask

  task automatic test_request_while_busy;
    int rc, rc2, p0, h0; bit ok;
    p0 = pulse_cnt; h0 = ar_hs;
    r_stall = 3; s_rdata = 32'hCAFE0001;
    issue(1'b0, 32'h0000_3000, 32'h0, 4'h0, rc);
    @(posedge clk); #1;                       // FSM now in RD_DATA
    issue(1'b0, 32'h0000_4000, 32'h0, 4'h0, rc2);
    wait_pulses(p0 + 1, ok);
    checks++; if (!ok || pulse_cyc - rc != 7) begin failures++; $display("FAIL busy_latency: got %0d expected 7", pulse_cyc - rc); end
    checks++; if (pulse_data !== 32'hCAFE0001) begin failures++; $display("FAIL busy_data: got %h expected cafe0001", pulse_data); end
    idle_cycles(10);
    checks++; if (pulse_cnt - p0 != 1 || ar_hs - h0 != 1) begin
      failures++; $display("FAIL busy_ignored: got pulses=%0d ar=%0d expected 1 1", pulse_cnt - p0, ar_hs - h0); end
    checks++; if (ar_addr_seen !== 32'h3000) begin failures++; $display("FAIL busy_addr: got %h expected 3000", ar_addr_seen); end
    r_stall = 0;
  endtask

  task automatic test_async_reset;
    int rc, p0; bit ok;
    logic [6:0] outs;
    p0 = pulse_cnt;
    b_stall = 5;
    issue(1'b1, 32'h0000_5000, 32'hAAAA5555, 4'hF, rc);
    @(posedge clk); #1;
    checks++; if (m_axi_bready !== 1'b1) begin failures++; $display("FAIL rst_in_wr_resp: got bready=%b expected 1", m_axi_bready); end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    outs = {m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy, response_enable, m_axi_arvalid, m_axi_rready};
    checks++; if (outs !== 7'h0 || m_axi_awaddr !== 32'h0 || m_axi_wdata !== 32'h0) begin
      failures++; $display("FAIL rst_immediate: got %b addr=%h data=%h expected 0", outs, m_axi_awaddr, m_axi_wdata); end
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    b_stall = 0;
    @(posedge clk); #1;
    idle_cycles(8);
    checks++; if (pulse_cnt != p0) begin failures++; $display("FAIL rst_no_pulse: got %0d pulses expected 0", pulse_cnt - p0); end
    s_rdata = 32'h0BADF00D;
    issue(1'b0, 32'h0000_6000, 32'h0, 4'h0, rc);
    wait_pulses(p0 + 1, ok);
    checks++; if (!ok || pulse_cyc - rc != 4 || pulse_data !== 32'h0BADF00D) begin
      failures++; $display("FAIL rst_recover: got lat=%0d data=%h expected 4 0badf00d", pulse_cyc - rc, pulse_data); end
  endtask

  task automatic test_back_to_back;
    int rc, rc2, p0; bit ok;
    p0 = pulse_cnt;
    s_rdata = 32'hA5A55A5A;
    issue(1'b0, 32'h0000_2000, 32'h0, 4'h0, rc);
    for (int i = 0; i < 20 && !response_enable; i++) begin @(posedge clk); #1; end
    issue(1'b1, 32'h0000_2100, 32'h11112222, 4'hF, rc2);
    wait_pulses(p0 + 2, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout: got %0d pulses expected 2", pulse_cnt - p0); end
    checks++; if (pulse_log[(p0 + 1) & 15] !== 32'hA5A55A5A || pulse_log[(p0 + 2) & 15] !== 32'h0) begin
      failures++; $display("FAIL b2b_order: got %h,%h expected a5a55a5a,0", pulse_log[(p0 + 1) & 15], pulse_log[(p0 + 2) & 15]); end
    checks++; if (pulse_cyc - rc2 != 4 || aw_addr_seen !== 32'h2100) begin
      failures++; $display("FAIL b2b_write: got lat=%0d addr=%h expected 4 2100", pulse_cyc - rc2, aw_addr_seen); end
    idle_cycles(3);
  endtask

  task automatic test_resp_codes;
    int rc, p0; bit ok;
    p0 = pulse_cnt;
    s_rdata = 32'hFFFF0000; s_rresp = 2'b11;
    issue(1'b0, 32'h0000_7000, 32'h0, 4'h0, rc);
    wait_pulses(p0 + 1, ok);
`ifdef MEM_BUS_ERR_EN
    checks++; if (!ok || pulse_data !== 32'h0 || pulse_fault !== 1'b1) begin
      failures++; $display("FAIL err_read: got data=%h fault=%b expected 0 1", pulse_data, pulse_fault); end
    checks++; if (access_fault !== 1'b1) begin failures++; $display("FAIL err_hold: got %b expected 1", access_fault); end
    s_rresp = 2'b00;
    issue(1'b0, 32'h0000_7004, 32'h0, 4'h0, rc);
    checks++; if (access_fault !== 1'b0) begin failures++; $display("FAIL err_clear: got %b expected 0", access_fault); end
    wait_pulses(p0 + 2, ok);
    checks++; if (!ok || pulse_fault !== 1'b0 || pulse_data !== 32'hFFFF0000) begin
      failures++; $display("FAIL err_ok_read: got data=%h fault=%b expected ffff0000 0", pulse_data, pulse_fault); end
`else
    checks++; if (!ok || pulse_data !== 32'hFFFF0000) begin
      failures++; $display("FAIL resp_ignored: got %h expected ffff0000", pulse_data); end
`endif
    s_rresp = 2'b00;
    idle_cycles(2);
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_stalls();
    test_request_while_busy();
    test_async_reset();
    test_back_to_back();
    test_resp_codes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
